serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder processes the operands LSB-first over
// WIDTH cycles, then presents a registered {cout, sum} with a one-cycle done pulse.

module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned    CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;
    // Holds the WIDTH-1 bits produced so far; the final bit joins on the last RUN edge.
    logic [WIDTH-2:0] res_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] res_d;

    full_adder u_fa (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_co)
    );

    // New sum bit enters at the MSB so the first-processed bit ends up at the LSB.
    always_comb begin
        res_d = {fa_s, res_q};
    end

    // Control FSM with datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= fa_co;
                    res_q   <= res_d[WIDTH-1:1];
                    cnt_q   <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        sum_q   <= res_d;
                        cout_q  <= fa_co;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed cases, disturbances,
// back-to-back operation and randomized operands against an arithmetic reference.

module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int total = 0;
    int bad   = 0;

    // Last result the block should be holding on sum/cout.
    logic [W:0] held;

    serial_add_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // disturb: 0 = none, 1 = re-pulse start mid-run, 2 = reset mid-run.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                         input int disturb);
        logic [W:0] ref_v;
        ref_v = (W+1)'(oa) + (W+1)'(ob) + (W+1)'(oc);
        @(negedge clk);
        start = 1'b1; a = oa; b = ob; cin = oc;
        @(negedge clk);  // after accept edge k
        chk("busy_at_k", 32'(busy), 32'd1);
        chk("done_at_k", 32'(done), 32'd0);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        for (int i = 1; i < W; i++) begin
            if (disturb == 1 && i == 3) begin
                start = 1'b1; a = 8'h11; b = 8'h22;
            end
            if (disturb == 1 && i == 4) start = 1'b0;
            if (disturb == 2 && i == 4) rst_n = 1'b0;
            @(negedge clk);  // after edge k+i
            if (disturb == 2 && i == 4) begin
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_sum", 32'(sum), 32'd0);
                chk("rst_cout", 32'(cout), 32'd0);
                held  = '0;
                rst_n = 1'b1;
                for (int j = 0; j < W + 2; j++) begin
                    @(negedge clk);
                    chk("no_done_after_abort", 32'(done), 32'd0);
                end
                return;
            end
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk("sum_held", 32'({cout, sum}), 32'(held));
        end
        @(negedge clk);  // after edge k+W
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("sum", 32'(sum), 32'(ref_v[W-1:0]));
        chk("cout", 32'(cout), 32'(ref_v[W]));
        held  = ref_v;
        start = 1'b1;  // must be ignored in DONE
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_ignore_done_start", 32'(busy), 32'd0);
        start = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("result_held", 32'({cout, sum}), 32'(held));
    endtask

    initial begin
        logic [7:0] pats [4];
        int         pulses;
        int         last;
        pats[0] = 8'h00; pats[1] = 8'h55; pats[2] = 8'hAA; pats[3] = 8'hFF;
        held  = '0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;

        do_op(8'h3C, 8'h0F, 1'b0, 0);
        do_op(8'hFF, 8'h01, 1'b0, 0);
        do_op(8'hA5, 8'h5A, 1'b1, 0);
        do_op(8'h3C, 8'h0F, 1'b0, 1);
        do_op(8'h3C, 8'h0F, 1'b0, 2);
        do_op(8'h3C, 8'h0F, 1'b0, 0);

        // Start held high: one result every W+2 cycles.
        @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
        pulses = 0;
        last   = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);  // after edge i (edge 0 accepts)
            if (done) begin
                pulses++;
                chk("b2b_sum", 32'(sum), 32'h02);
                if (last < 0) chk("b2b_first", 32'(i), 32'(W));
                else          chk("b2b_period", 32'(i - last), 32'(W + 2));
                last = i;
            end
        end
        chk("b2b_pulses", 32'(pulses), 32'd4);
        start = 1'b0;
        held  = 9'h002;
        repeat (3) @(negedge clk);

        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    do_op(pats[i], pats[j], 1'(c), 0);

        for (int n = 0; n < 20; n++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
